// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and helpers for the M-extension multiply/divide sequencer
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic is_div(op_e op);
        return op[2];
    endfunction

    // rs2_side selects the operand; MULHSU is signed only on rs1
    function automatic logic is_signed(op_e op, logic rs2_side);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            OP_MULHSU:               return !rs2_side;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide datapath
// MULDIV_EARLY_OUT_EN: multiply may stop once the remaining multiplier bits are zero
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     step,
    input  logic                     fix,
    input  logic [2:0]               op,
    input  logic [XLEN-1:0]          rs1,
    input  logic [XLEN-1:0]          rs2,
    output logic                     special,
`ifdef MULDIV_EARLY_OUT_EN
    input  logic [$clog2(XLEN)-1:0]  cnt,
    output logic                     early_done,
`endif
    output logic [XLEN-1:0]          result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    op_e             op_in, op_q;
    logic [XLEN-1:0] hi, lo, opnd, result_q;
    logic            neg_a, neg_b;

    assign op_in = op_e'(op);

    logic            sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] abs1, abs2, special_val;

    always_comb begin
        sa       = is_signed(op_in, 1'b0) && rs1[XLEN-1];
        sb       = is_signed(op_in, 1'b1) && rs2[XLEN-1];
        abs1     = sa ? -rs1 : rs1;
        abs2     = sb ? -rs2 : rs2;
        div_zero = is_div(op_in) && (rs2 == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (rs1 == MIN_NEG) && (rs2 == '1);
        special  = div_zero || div_ovf;
        // op[1] clear means a quotient op, set means a remainder op
        if (!op_in[1]) special_val = div_zero ? '1 : rs1;
        else           special_val = div_zero ? rs1 : '0;
    end

    // {hi,lo} is the product/multiplier pair for multiply and remainder/quotient pair for divide
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [XLEN-1:0] mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
    logic            rem_ge;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        mul_hi_nx = mul_sum[XLEN:1];
        mul_lo_nx = {mul_sum[0], lo[XLEN-1:1]};
        rem_sh    = {hi, lo[XLEN-1]};
        rem_ge    = rem_sh >= {1'b0, opnd};
        div_hi_nx = rem_ge ? (rem_sh[XLEN-1:0] - opnd) : rem_sh[XLEN-1:0];
        div_lo_nx = {lo[XLEN-2:0], rem_ge};
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0]         left_mask;
    logic [$clog2(XLEN)-1:0] align;

    // after iteration cnt, XLEN-1-cnt multiplier bits remain unconsumed
    assign left_mask  = {XLEN{1'b1}} >> (32'(cnt) + 32'd1);
    assign early_done = !is_div(op_q) && ((mul_lo_nx & left_mask) == '0);
    // cnt has wrapped to 0 after a full run, so this is XLEN - iterations done, mod XLEN
    assign align      = '0 - cnt;
`endif

    logic [2*XLEN-1:0] prod_abs, prod;
    logic [XLEN-1:0]   quot, rmd, fix_val;

    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        prod_abs = {hi, lo} >> align;
`else
        prod_abs = {hi, lo};
`endif
        prod = (neg_a ^ neg_b) ? -prod_abs : prod_abs;
        quot = (neg_a ^ neg_b) ? -lo : lo;
        rmd  = neg_a ? -hi : hi;
        case (op_q)
            OP_MUL:                        fix_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_val = quot;
            default:                       fix_val = rmd;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_MUL;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_q <= '0;
        end else if (load) begin
            op_q  <= op_in;
            neg_a <= sa;
            neg_b <= sb;
            hi    <= '0;
            lo    <= is_div(op_in) ? abs1 : abs2;
            opnd  <= is_div(op_in) ? abs2 : abs1;
            if (special) begin
                result_q <= special_val;
            end
        end else if (step) begin
            hi <= is_div(op_q) ? div_hi_nx : mul_hi_nx;
            lo <= is_div(op_q) ? div_lo_nx : mul_lo_nx;
        end else if (fix) begin
            result_q <= fix_val;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - handshake, flush and FSM control for the iterative multiply/divide unit
// MULDIV_EARLY_OUT_EN: variable-latency multiply when the multiplier runs out of set bits
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             load, step, fix, special, calc_last;

`ifdef MULDIV_EARLY_OUT_EN
    logic early_done;
    assign calc_last = (cnt == CNT_W'(XLEN-1)) || early_done;
`else
    assign calc_last = (cnt == CNT_W'(XLEN-1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_valid) state_nx = special ? DONE : CALC;
                CALC:    if (calc_last) state_nx = FIX;
                FIX:     state_nx = DONE;
                DONE:    if (result_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        start_ready  = (state == IDLE);
        result_valid = (state == DONE);
        busy         = (state != IDLE);
        load         = (state == IDLE) && start_valid && !flush;
        step         = (state == CALC) && !flush;
        fix          = (state == FIX) && !flush;
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .fix        (fix),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .special    (special),
`ifdef MULDIV_EARLY_OUT_EN
        .cnt        (cnt),
        .early_done (early_done),
`endif
        .result     (result)
    );

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), which the decode ROM dispatches as ALU-class R-type ops.
- Accepts one operation via a valid/ready handshake and runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Holds the result until the writeback stage takes it.
- Drives `busy` so the hazard unit stalls the pipeline while an op is in flight.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 2 and a power of two.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start_valid  input  1  op request
- start_ready  output  1  sequencer can accept
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  XLEN  dividend / multiplicand
- rs2  input  XLEN  divisor / multiplier
- flush  input  1  synchronous abort (branch mispredict / trap)
- result_valid  output  1  result available
- result_ready  input  1  writeback accepts result
- result  output  XLEN  computed value
- busy  output  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state = IDLE, start_ready = 1, result_valid = 0, result = 0, busy = 0. All internal registers are cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready & !flush: latch op; latch |rs1| and |rs2| for signed operands (MULHSU treats only rs1 as signed); record sign flags; counter = 0.
  - Next state: DONE if a special case applies, else CALC.
- Special cases (result is computed in the accept cycle):
  - DIV/DIVU with rs2 = 0: quotient = all ones.
  - REM/REMU with rs2 = 0: result = rs1.
  - DIV with rs1 = -2^(XLEN-1) and rs2 = -1: result = -2^(XLEN-1).
  - REM with the same operands: result = 0.
- CALC:
  - One iteration per cycle for exactly XLEN cycles; counter increments each cycle.
  - Multiply: 2*XLEN-bit accumulator; add multiplicand if multiplier LSB is 1, then shift.
  - Divide: restoring; shift remainder left, trial-subtract divisor, set quotient bit if non-negative.
  - After the iteration with counter = XLEN-1, go to FIX.
- FIX (1 cycle):
  - Negate the product if sign flags differ.
  - Negate the quotient if dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Select the result: low half (MUL), high half (MULH*), quotient, or remainder.
  - Go to DONE.
- DONE:
  - result_valid = 1; result is stable until the handshake.
  - On result_ready, return to IDLE. No new op is accepted in the same cycle.
- Latency: accept edge at cycle 0. Normal ops raise result_valid at cycle XLEN+2; special cases at cycle 1.
- Throughput: one op per XLEN+3 cycles minimum.
- flush: from any state, next state = IDLE and result_valid drops the next cycle. flush and start_valid in the same cycle: no accept.
- reset mid-operation: immediate return to IDLE; the in-flight op is discarded.
- start_valid while not IDLE is ignored because start_ready = 0.
- busy = (state != IDLE).

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply ops leave CALC early when the remaining shifted multiplier bits are all zero. The accumulator is aligned by the remaining shift amount in FIX.
  - Latency is variable, minimum 3 (rs2 = 0 or 1: CALC 1 cycle, FIX, DONE).
  - Divide latency is unchanged.
- Undefined: fixed latency XLEN+2 for every non-special op.

Decomposition:
- Shared package muldiv_pkg:
  - XLEN default.
  - op_e enum (funct3 values above).
  - state_e enum.
  - is_div / is_signed helper functions.
- One sub-module, muldiv_datapath: accumulator, remainder and quotient registers, plus the adder/subtractor, controlled by the sequencer's step and fix strobes.
- The FSM, handshake and flush logic stay in muldiv_sequencer.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), result_ready = 1 → result_valid at cycle 34, result = 0xFFFFFFEB, busy high for cycles 1–34.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result = 0xFFFFFFFE. MULH of the same operands → 0x00000000.
- DIV -7 / 2 → 0xFFFFFFFD. REM -7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF at cycle 1. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Hold result_ready = 0 for 5 cycles in DONE → result_valid and result stay stable, start_ready = 0. Then result_ready = 1 → IDLE next cycle.
- flush at cycle 10 of CALC → IDLE at cycle 11, result_valid never rises. Assert reset mid-CALC → outputs reach reset values without waiting for a clock edge.
